wasca_pio_in_edge: RTL and testbench

// Parametrised Avalon-MM input PIO: generalises the 1-bit read-only input port to WIDTH channels.

---
 rtl/wasca_pio_in_edge.sv | 166 ++++++++++++++++
 tb/tb_wasca_pio_in_edge.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wasca_pio_in_edge.sv
// wasca_pio_in_edge: Avalon-MM input PIO with WIDTH channels.
// Each channel is synchronised and optionally debounced. Selected edges are held
// in sticky capture bits, which are gated by a mask onto one level interrupt.
// Register map: 0 DATA (RO), 1 reserved (reads 0), 2 MASK (RW), 3 CAPTURE (W1C).
module wasca_pio_in_edge #(
  parameter int WIDTH       = 8,  // 1..32 input channels
  parameter int SYNC_STAGES = 2,  // 2..4 synchroniser flops
  parameter int DEBOUNCE    = 0,  // stable cycles before a change is accepted, 0 = bypass
  parameter int EDGE_MODE   = 0   // 0 = rising, 1 = falling, 2 = any edge
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int ARM_LAST = SYNC_STAGES + 1;
  localparam int AW       = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_out;
  logic [AW-1:0]                     arm_q;
  logic                              armed;
  logic [WIDTH-1:0]                  filtered;
  logic [WIDTH-1:0]                  prev_q;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;
  logic [WIDTH-1:0]                  edge_sel;
  logic [WIDTH-1:0]                  edge_hit;
  logic [WIDTH-1:0]                  mask_q;
  logic [WIDTH-1:0]                  capture_q;
  logic [WIDTH-1:0]                  capture_d;
  logic [WIDTH-1:0]                  clear_bits;
  logic [31:0]                       rdata_d;
  logic                              wr_en;
  logic                              unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign sync_out     = sync_q[SYNC_STAGES-1];
  assign armed        = (arm_q == AW'(ARM_LAST));
  assign unused_wdata = ^writedata;

  // Shift the asynchronous lines through the synchroniser chain.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all flops sample the
    // pre-edge values and simulation order between blocks cannot matter.
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  // Arm counter: suppress edges until the synchroniser holds real line values.
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_q <= '0;
    end else if (!armed) begin
      arm_q <= arm_q + AW'(1);
    end
  end

  // Debounce filter, or a straight pass-through when DEBOUNCE is zero.
  if (DEBOUNCE > 0) begin : g_debounce
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [WIDTH-1:0][CW-1:0] cnt_q;
    logic [WIDTH-1:0]         stable_q;

    // Per channel: count consecutive disagreeing cycles, accept on the DEBOUNCE-th.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q    <= '0;
        stable_q <= '0;
      end else if (!armed) begin
        cnt_q    <= '0;
        stable_q <= sync_out;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (sync_out[i] == stable_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
            stable_q[i] <= sync_out[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end
      end
    end

    assign filtered = stable_q;
  end else begin : g_bypass
    assign filtered = sync_out;
  end

  // Remember last cycle's filtered value; during arming track the line directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= armed ? filtered : sync_out;
    end
  end

  assign rise = filtered & ~prev_q;
  assign fall = ~filtered & prev_q;

  // Pick the edge polarity this instance reports.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // edge_sel unassigned, which would otherwise infer a latch.
    edge_sel = '0;
    case (EDGE_MODE)
      0:       edge_sel = rise;
      1:       edge_sel = fall;
      default: edge_sel = rise | fall;
    endcase
  end

  assign edge_hit   = armed ? edge_sel : '0;
  assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  // A new edge is OR-ed in after the clear, so a simultaneous set wins.
  assign capture_d  = (capture_q & ~clear_bits) | edge_hit;

  // Sticky capture bits and the interrupt mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      capture_q <= '0;
      mask_q    <= '0;
    end else begin
      capture_q <= capture_d;
      if (wr_en && address == 2'd2) begin
        mask_q <= writedata[WIDTH-1:0];
      end
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rdata_d = '0;
    case (address)
      2'd0:    rdata_d[WIDTH-1:0] = filtered;
      2'd2:    rdata_d[WIDTH-1:0] = mask_q;
      2'd3:    rdata_d[WIDTH-1:0] = capture_q;
      default: rdata_d = '0;
    endcase
  end

  // Register read data every cycle; there is no read strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rdata_d;
    end
  end

  assign irq = |(capture_q & mask_q);

endmodule

// File: tb/tb_wasca_pio_in_edge.sv
// Bench for wasca_pio_in_edge: four instances (default, debounced, any-edge,
// falling-edge) share one bus and one set of input lines. A behavioural model
// predicts every instance each cycle; hand-written vectors and sequences cover
// the timing corner cases.
module tb_wasca_pio_in_edge;

  localparam int NI   = 4;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd [NI];
  logic        irq_w [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wasca_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(SYNC), .DEBOUNCE(0), .EDGE_MODE(0)) u_def (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq_w[0]));
  wasca_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(SYNC), .DEBOUNCE(4), .EDGE_MODE(0)) u_deb (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq_w[1]));
  wasca_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(SYNC), .DEBOUNCE(0), .EDGE_MODE(2)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq_w[2]));
  wasca_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(SYNC), .DEBOUNCE(0), .EDGE_MODE(1)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[3]), .irq(irq_w[3]));

  // ---------------- behavioural reference model ----------------
  int         deb_of  [NI] = '{0, 4, 0, 0};
  int         mode_of [NI] = '{0, 0, 2, 1};
  logic [7:0] m_hist [$];          // line samples, newest first
  int         m_since;             // edges since reset release
  logic [7:0] m_accepted [NI];     // debounced value
  logic [7:0] m_last_seen [NI];    // filtered value at the previous edge
  logic [7:0] m_mask [NI];
  logic [7:0] m_cap [NI];
  int         m_streak [NI][8];    // consecutive cycles line disagreed with accepted value
  logic [31:0] m_rd [NI];

  task automatic model_edge();
    logic [7:0] line;
    logic [7:0] filt;
    logic [7:0] edges;
    logic [7:0] clr;
    logic       wr;
    logic       arming;
    if (reset) begin
      m_hist  = '{8'h00, 8'h00};
      m_since = 0;
      for (int k = 0; k < NI; k++) begin
        m_accepted[k] = '0; m_last_seen[k] = '0; m_mask[k] = '0; m_cap[k] = '0; m_rd[k] = '0;
        for (int b = 0; b < 8; b++) m_streak[k][b] = 0;
      end
      return;
    end
    line   = m_hist[SYNC-1];
    arming = (m_since < SYNC + 1);
    wr     = chipselect && !write_n;
    for (int k = 0; k < NI; k++) begin
      filt = (deb_of[k] > 0) ? m_accepted[k] : line;
      case (address)
        2'd0:    m_rd[k] = {24'h0, filt};
        2'd2:    m_rd[k] = {24'h0, m_mask[k]};
        2'd3:    m_rd[k] = {24'h0, m_cap[k]};
        default: m_rd[k] = 32'h0;
      endcase
      edges = '0;
      if (!arming) begin
        for (int b = 0; b < 8; b++) begin
          if (filt[b] != m_last_seen[k][b]) begin
            if (mode_of[k] == 2 || (mode_of[k] == 0 && filt[b]) || (mode_of[k] == 1 && !filt[b]))
              edges[b] = 1'b1;
          end
        end
      end
      clr = (wr && address == 2'd3) ? writedata[7:0] : 8'h00;
      m_cap[k] = (m_cap[k] & ~clr) | edges;
      if (wr && address == 2'd2) m_mask[k] = writedata[7:0];
      m_last_seen[k] = arming ? line : filt;
      if (deb_of[k] > 0) begin
        for (int b = 0; b < 8; b++) begin
          if (arming || line[b] == m_accepted[k][b]) begin
            if (arming) m_accepted[k][b] = line[b];
            m_streak[k][b] = 0;
          end else begin
            m_streak[k][b]++;
            if (m_streak[k][b] >= deb_of[k]) begin
              m_accepted[k][b] = line[b];
              m_streak[k][b]   = 0;
            end
          end
        end
      end
    end
    m_hist.push_front(in_port);
    void'(m_hist.pop_back());
    if (arming) m_since++;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: model follows the edge, every instance is compared at the negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("model readdata inst%0d", k), rd[k], m_rd[k]);
      check($sformatf("model irq inst%0d", k), {31'h0, irq_w[k]}, {31'h0, |(m_cap[k] & m_mask[k])});
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    idle();
  endtask

  typedef struct {
    logic [7:0]  in;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [11];
  int   first_irq;
  logic saw_data;

  initial begin
    // Expected values for the default instance: rising edge on bit3, mask, W1C.
    tbl[0]  = '{8'hA5, 1'b0, 2'd0, 32'h0,  32'hA5, 1'b0};
    tbl[1]  = '{8'hA5, 1'b0, 2'd3, 32'h0,  32'h00, 1'b0};
    tbl[2]  = '{8'hA5, 1'b0, 2'd1, 32'h0,  32'h00, 1'b0};
    tbl[3]  = '{8'hA5, 1'b1, 2'd2, 32'h08, 32'h00, 1'b0};
    tbl[4]  = '{8'hAD, 1'b0, 2'd2, 32'h0,  32'h08, 1'b0};
    tbl[5]  = '{8'hAD, 1'b0, 2'd3, 32'h0,  32'h00, 1'b0};
    tbl[6]  = '{8'hAD, 1'b0, 2'd3, 32'h0,  32'h00, 1'b1};
    tbl[7]  = '{8'hAD, 1'b0, 2'd3, 32'h0,  32'h08, 1'b1};
    tbl[8]  = '{8'hAD, 1'b1, 2'd3, 32'h08, 32'h08, 1'b0};
    tbl[9]  = '{8'hAD, 1'b0, 2'd3, 32'h0,  32'h00, 1'b0};
    tbl[10] = '{8'hAD, 1'b0, 2'd0, 32'h0,  32'hAD, 1'b0};

    // Reset with lines already at A5.
    reset = 1'b1; in_port = 8'hA5; address = 2'd0; writedata = '0; idle();
    steps(3);
    check("irq during reset", {31'h0, irq_w[0]}, 32'h0);
    reset = 1'b0;
    step();
    check("irq after release", {31'h0, irq_w[0]}, 32'h0);
    steps(4);

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      in_port    = tbl[i].in;
      address    = tbl[i].addr;
      writedata  = tbl[i].wd;
      chipselect = tbl[i].we;
      write_n    = ~tbl[i].we;
      step();
      check($sformatf("vec%0d readdata", i), rd[0], tbl[i].exp_rd);
      check($sformatf("vec%0d irq", i), {31'h0, irq_w[0]}, {31'h0, tbl[i].exp_irq});
    end
    idle();

    // Debounce: a 3-cycle pulse never reaches DATA or CAPTURE.
    in_port = 8'h00; steps(12);
    wr_reg(2'd3, 32'hFF);
    wr_reg(2'd2, 32'h01);
    address = 2'd0;
    for (int c = 0; c < 13; c++) begin
      in_port = (c < 3) ? 8'h01 : 8'h00;
      step();
      check("deb short data bit0", {31'h0, rd[1][0]}, 32'h0);
      check("deb short irq", {31'h0, irq_w[1]}, 32'h0);
    end
    // A 5-cycle pulse is accepted; capture lands SYNC_STAGES+5 cycles after the change.
    wr_reg(2'd3, 32'hFF);
    address = 2'd0; first_irq = -1; saw_data = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_port = (c < 5) ? 8'h01 : 8'h00;
      step();
      if (irq_w[1] && first_irq < 0) first_irq = c + 1;
      if (rd[1][0]) saw_data = 1'b1;
    end
    check("deb long capture latency", first_irq, SYNC + 5);
    check("deb long data seen", {31'h0, saw_data}, 32'h1);

    // Set/clear collision on bit2: the edge wins.
    in_port = 8'h00; steps(12);
    wr_reg(2'd3, 32'hFF);
    in_port = 8'h04;
    steps(2);
    wr_reg(2'd3, 32'h04);
    address = 2'd3;
    step();
    check("collision capture def", rd[0], 32'h04);
    check("collision capture any", rd[2], 32'h04);

    // Edge modes on bit7: 1->0 then 0->1.
    in_port = 8'h80; steps(12);
    wr_reg(2'd3, 32'hFF);
    in_port = 8'h00; steps(4);
    address = 2'd3; step();
    check("fall edge any", rd[2], 32'h80);
    check("fall edge fallmode", rd[3], 32'h80);
    check("fall edge risemode", rd[0], 32'h00);
    wr_reg(2'd3, 32'hFF);
    in_port = 8'h80; steps(4);
    address = 2'd3; step();
    check("rise edge any", rd[2], 32'h80);
    check("rise edge fallmode", rd[3], 32'h00);
    check("rise edge risemode", rd[0], 32'h80);

    // Reset mid-operation, with a mask write in the reset cycle.
    in_port = 8'h00; steps(12);
    wr_reg(2'd3, 32'hFF);
    wr_reg(2'd2, 32'hFF);
    in_port = 8'hFF; steps(6);
    address = 2'd3; step();
    check("pre-reset capture", rd[0], 32'hFF);
    check("pre-reset irq", {31'h0, irq_w[0]}, 32'h1);
    reset = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h55;
    step();
    reset = 1'b0; idle();
    check("irq after mid reset", {31'h0, irq_w[0]}, 32'h0);
    address = 2'd2; step();
    check("mask after mid reset", rd[0], 32'h0);
    address = 2'd3; step();
    check("capture after mid reset", rd[0], 32'h0);
    address = 2'd1; step();
    check("reserved reads zero", rd[0], 32'h0);
    steps(6);

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) in_port = 8'($urandom);
      address = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) begin
        chipselect = 1'b1; write_n = 1'b0; writedata = $urandom;
      end else begin
        idle();
      end
      step();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
